uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the RISC-V core's picorv32-style native memory bus. It is decoded alongside the GPIO register block.

- Firmware writes bytes into a small FIFO.
- A baud-divided serializer shifts them out LSB-first, 8N1, on one top-level output pin.
- The top muxes `mem_rdata`/`mem_ready` from this block when `sel_o` is high.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_tx_fifo.sv | 62 ++++++
 rtl/uart_tx_mmio.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and serializer states.
package uart_tx_pkg;

  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_DIV    = 4'h8;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_ACTIVE = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_LVL_LO = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO for the UART transmitter; a push while full is
// accepted when a pop happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_LVL);
  assign level   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on a picorv32-style native bus.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames).
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR  = 32'h0200_0010,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(103),
  parameter int               FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        sel_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      offset;
  logic [3:0]       ofs;
  logic             ready_reg;
  logic             ack_reg;
  logic             access;
  logic             wr;
  logic             push;
  logic             pop;
  logic             ovf_clr;
  logic             div_wr;
  logic             ovf_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic [31:0]      status;
  logic [31:0]      rdata_mux;
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;

  state_t           state;
  logic             tx_reg;
  logic [DIV_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_lat;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
`ifdef UART_TX_PARITY_EN
  logic             par_reg;
`endif

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata_i;

  // Subtraction wraps addresses below the base to large values, so one compare covers both ends.
  assign offset = mem_addr_i - BASE_ADDR;
  assign ofs    = {offset[3:2], 2'b00};
  assign sel_o  = mem_valid_i && (offset < 32'd12);

  assign access  = ready_reg && sel_o;
  assign wr      = access && (mem_wstrb_i != 4'b0000);
  assign push    = wr && (ofs == OFS_DATA) && mem_wstrb_i[0];
  assign ovf_clr = wr && (ofs == OFS_STATUS) && mem_wstrb_i[0] && mem_wdata_i[ST_OVF];
  assign div_wr  = wr && (ofs == OFS_DIV);
  assign pop     = (state == IDLE) && !fifo_empty;

  for (genvar gi = 0; gi < DIV_W; gi++) begin : g_div_byte
    assign div_next[gi] = mem_wstrb_i[gi / 8] ? mem_wdata_i[gi] : div_reg[gi];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_reg <= 1'b0;
      ack_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      div_reg   <= DIV_RESET;
    end else begin
      // ack_reg holds off a second ack while the master keeps valid high after ready.
      ready_reg <= sel_o && !ready_reg && !ack_reg;
      ack_reg   <= mem_valid_i && (ack_reg || ready_reg);
      if (push && fifo_full && !pop) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
      if (div_wr) begin
        div_reg <= div_next;
      end
    end
  end

  always_comb begin
    status                         = '0;
    status[ST_FULL]                = fifo_full;
    status[ST_EMPTY]               = fifo_empty;
    status[ST_ACTIVE]              = (state != IDLE);
    status[ST_OVF]                 = ovf_reg;
    status[ST_LVL_LO +: LVL_W]     = fifo_level;
    rdata_mux                      = '0;
    case (ofs)
      OFS_STATUS: rdata_mux = status;
      OFS_DIV:    rdata_mux[DIV_W-1:0] = div_reg;
      default:    rdata_mux = '0;
    endcase
  end

  assign mem_rdata_o = access ? rdata_mux : '0;
  assign mem_ready_o = ready_reg;
  assign tx_o        = tx_reg;
  assign busy_o      = (state != IDLE) || !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (mem_wdata_i[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // bit_cnt counts down from the divisor latched at frame start; zero ends a bit period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      tx_reg    <= 1'b1;
      bit_cnt   <= '0;
      div_lat   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_reg <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_rdata;
            div_lat   <= div_reg;
            bit_cnt   <= div_reg;
            tx_reg    <= 1'b0;
            state     <= START;
`ifdef UART_TX_PARITY_EN
            par_reg   <= ^fifo_rdata;
`endif
          end
        end
        START: begin
          if (bit_cnt == '0) begin
            bit_cnt <= div_lat;
            bit_idx <= '0;
            tx_reg  <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_cnt == '0) begin
            bit_cnt <= div_lat;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_reg <= par_reg;
              state  <= PARITY;
`else
              tx_reg <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_cnt == '0) begin
            bit_cnt <= div_lat;
            tx_reg  <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_cnt == '0) begin
            state <= IDLE;
          end else begin
            bit_cnt <= bit_cnt - DIV_W'(1);
          end
        end
        default: begin
          tx_reg <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: bus reads and serial frames are checked
// by monitors against queues filled by the stimulus.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'h0200_0010;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_DIV  = BASE + 32'h8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         gap_chk;
  } tx_exp_t;

  typedef struct {
    logic [31:0] data;
    bit          chk;
    string       tag;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        sel;
  logic        tx;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int frames_done = 0;
  int last_end = 0;

  tx_exp_t exp_tx[$];
  rd_exp_t exp_rd[$];

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .mem_valid_i (mem_valid),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_wstrb_i (mem_wstrb),
    .mem_rdata_o (mem_rdata),
    .mem_ready_o (mem_ready),
    .sel_o       (sel),
    .tx_o        (tx),
    .busy_o      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    int n = 0;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    while (mem_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout addr=%h actual=no ready required=ready", addr);
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    rd_exp_t e;
    e.data = '0;
    e.chk  = 1'b0;
    e.tag  = "wr";
    exp_rd.push_back(e);
    bus(addr, wdata, wstrb);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    e.data = exp;
    e.chk  = 1'b1;
    e.tag  = tag;
    exp_rd.push_back(e);
    bus(addr, 32'h0, 4'b0000);
  endtask

  task automatic push_tx(input logic [7:0] data, input int div, input bit gap);
    tx_exp_t e;
    e.data    = data;
    e.div     = div;
    e.gap_chk = gap;
    exp_tx.push_back(e);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (frames_done < target) begin
      checks++;
      errors++;
      $display("FAIL %s actual=%0d frames required=%0d", tag, frames_done, target);
    end
  endtask

  // Bus monitor: every ack consumes one expectation.
  always @(negedge clk) begin
    rd_exp_t r;
    if (!rst_i && mem_ready === 1'b1) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected_ack addr=%h actual=ack required=no ack", mem_addr);
      end else begin
        r = exp_rd.pop_front();
        if (r.chk) begin
          check(r.tag, mem_rdata, r.data);
          $display("rd %s rdata=%h", r.tag, mem_rdata);
        end else begin
          $display("wr ack addr=%h", mem_addr);
        end
      end
    end
  end

  // Serial monitor: checks every sampled cycle of a frame against the expected bit level.
  bit          mon_active = 1'b0;
  bit          unexp = 1'b0;
  bit          frame_bad;
  int          bit_i;
  int          cyc;
  int          bad_bit;
  logic        bad_act;
  logic [10:0] fbits;
  tx_exp_t     cur;

  always @(negedge clk) begin
    cyc_cnt++;
    if (rst_i) begin
      mon_active = 1'b0;
      unexp      = 1'b0;
    end else begin
      if (!mon_active) begin
        if (tx !== 1'b0) begin
          unexp = 1'b0;
        end else if (exp_tx.size() == 0) begin
          if (!unexp) begin
            checks++;
            errors++;
            $display("FAIL tx_start actual=unexpected start bit required=idle high");
          end
          unexp = 1'b1;
        end else begin
          cur = exp_tx.pop_front();
          if (cur.gap_chk) begin
            checks++;
            if (cyc_cnt - last_end != 2) begin
              errors++;
              $display("FAIL frame_gap data=%h actual=%0d required=2", cur.data, cyc_cnt - last_end);
            end
          end
`ifdef UART_TX_PARITY_EN
          fbits = {1'b1, ^cur.data, cur.data, 1'b0};
`else
          fbits = {2'b11, cur.data, 1'b0};
`endif
          mon_active = 1'b1;
          bit_i      = 0;
          cyc        = 0;
          frame_bad  = 1'b0;
        end
      end
      if (mon_active) begin
        if (tx !== fbits[bit_i] && !frame_bad) begin
          frame_bad = 1'b1;
          bad_bit   = bit_i;
          bad_act   = tx;
        end
        cyc++;
        if (cyc == cur.div + 1) begin
          cyc = 0;
          bit_i++;
          if (bit_i == NBITS) begin
            checks++;
            if (frame_bad) begin
              errors++;
              $display("FAIL frame data=%h bit %0d actual=%b required=%b",
                       cur.data, bad_bit, bad_act, fbits[bad_bit]);
            end
            $display("tx frame data=%h div=%0d", cur.data, cur.div);
            mon_active = 1'b0;
            frames_done++;
            last_end = cyc_cnt;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] bad_addr [3];
    logic [7:0]  burst [6];
    int          f0;

    bad_addr = '{BASE + 32'h20, BASE + 32'hC, BASE - 32'h4};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk); #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", mem_ready, 0);
    check("rst_rdata", mem_rdata, 0);
    rd(A_STAT, 32'h2, "rst_status");
    rd(A_DIV, 32'd103, "rst_div");

    // DIV=3, single frame of 0x55 with exact start latency
    wr(A_DIV, 32'd3, 4'b0011);
    rd(A_DIV, 32'd3, "div3");
    push_tx(8'h55, 3, 1'b0);
    wr(A_DATA, 32'h55, 4'b0001);
    check("n1_tx", tx, 1);
    check("n1_busy", busy, 1);
    @(posedge clk); #1;
    check("n2_tx", tx, 0);
    wait_frames(1, 100, "frame55");
    repeat (2) @(posedge clk);
    #1 check("idle_busy", busy, 0);

    // Per-byte DIV strobes, then DIV=0 with a five-byte burst
    wr(A_DIV, 32'h0000AB00, 4'b0010);
    rd(A_DIV, 32'h0000AB03, "div_hi_byte");
    wr(A_DIV, 32'h0, 4'b0011);
    rd(A_DIV, 32'h0, "div0");
    burst = '{8'h01, 8'h80, 8'hFE, 8'h7F, 8'h5A, 8'h00};
    f0 = frames_done;
    for (int i = 0; i < 5; i++) begin
      push_tx(burst[i], 0, i != 0);
      wr(A_DATA, {24'h0, burst[i]}, 4'b0001);
    end
    wait_frames(f0 + 5, 200, "burst_div0");
    repeat (3) @(posedge clk);
    rd(A_STAT, 32'h2, "burst_status");

    // DIV=99, six rapid writes: one overflows
    wr(A_DIV, 32'd99, 4'b0011);
    burst = '{8'hA5, 8'h00, 8'h3C, 8'hFF, 8'h81, 8'h99};
    f0 = frames_done;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) push_tx(burst[i], 99, i != 0);
      wr(A_DATA, {24'h0, burst[i]}, 4'b0001);
    end
    rd(A_STAT, 32'h4D, "ovf_status");
    wr(A_STAT, 32'h8, 4'b0001);
    rd(A_STAT, 32'h45, "ovf_cleared");
    wait_frames(f0 + 1, 1500, "frame_div99");

    // Asynchronous reset in the middle of the all-zero data bits of byte 0x00
    repeat (150) @(posedge clk);
    #1 check("pre_rst_tx", tx, 0);
    #2;
    exp_tx.delete();
    rst_i = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    rd(A_STAT, 32'h2, "post_rst_status");
    rd(A_DIV, 32'd103, "post_rst_div");

    // Foreign addresses are never selected or acked
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = bad_addr[i];
      mem_wdata = 32'hEE;
      mem_wstrb = 4'b0001;
      repeat (4) begin
        @(posedge clk); #1;
        check("foreign_sel", sel, 0);
        check("foreign_ready", mem_ready, 0);
      end
      mem_valid = 1'b0;
      mem_wstrb = '0;
    end
    rd(A_DATA, 32'h0, "data_read");
    rd(A_STAT, 32'h2, "status_after_foreign");

    repeat (20) @(posedge clk);
    #1;
    check("tx_queue_left", exp_tx.size(), 0);
    check("rd_queue_left", exp_rd.size(), 0);
    check("final_tx", tx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
